// File: rtl/alu_uart_host.sv
// alu_uart_host: sends {A, B, op} as three UART bytes, then waits for one result byte or a timeout.
module alu_uart_host #(
   parameter int NB_DATA    = 8,
   parameter int NB_CODE    = 6,
   parameter int NB_TIMEOUT = 18,
   parameter int TIMEOUT    = 200000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_cmd_valid,
   output logic               o_cmd_ready,
   input  logic [NB_DATA-1:0] i_data_a,
   input  logic [NB_DATA-1:0] i_data_b,
   input  logic [NB_CODE-1:0] i_op,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_tx_data,
   input  logic               i_tx_done,
   input  logic               i_rx_done,
   input  logic [NB_DATA-1:0] i_rx_data,
   output logic [NB_DATA-1:0] o_result,
   output logic               o_result_valid,
   output logic               o_timeout,
   output logic               o_busy
);
   typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, WAIT_RX} state_t;
   state_t                r_state;
   logic [1:0]            r_idx;
   logic [NB_TIMEOUT-1:0] r_cnt;
   logic [NB_DATA-1:0]    r_b;
   logic [NB_CODE-1:0]    r_op;
   logic [NB_DATA-1:0]    r_tx_data;
   logic [NB_DATA-1:0]    r_result;
   logic                  r_valid;
   logic                  r_timeout;
   logic                  w_last;
   logic [NB_DATA-1:0]    w_op_byte;
   assign w_last    = r_cnt == NB_TIMEOUT'(TIMEOUT - 1);
   assign w_op_byte = NB_DATA'(r_op);
   // A goes straight into the TX byte register on acceptance; only B and op need holding
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= IDLE;
         r_idx     <= 2'd0;
         r_cnt     <= '0;
         r_b       <= '0;
         r_op      <= '0;
         r_tx_data <= '0;
         r_result  <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: if (i_cmd_valid) begin
               r_b       <= i_data_b;
               r_op      <= i_op;
               r_tx_data <= i_data_a;
               r_idx     <= 2'd0;
               r_state   <= SEND;
            end
            SEND: r_state <= WAIT_TX;
            WAIT_TX: if (i_tx_done) begin
               if (r_idx == 2'd2) begin
                  r_cnt   <= '0;
                  r_state <= WAIT_RX;
               end else begin
                  r_idx     <= r_idx + 2'd1;
                  r_tx_data <= (r_idx == 2'd0) ? r_b : w_op_byte;
                  r_state   <= SEND;
               end
            end
            WAIT_RX: begin
               r_cnt <= r_cnt + NB_TIMEOUT'(1);
               // a result arriving on the terminal count beats the timeout
               if (i_rx_done) begin
                  r_result <= i_rx_data;
                  r_valid  <= 1'b1;
                  r_state  <= IDLE;
               end else if (w_last) begin
                  r_timeout <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign o_cmd_ready    = r_state == IDLE;
   assign o_busy         = r_state != IDLE;
   assign o_tx_start     = r_state == SEND;
   assign o_tx_data      = r_tx_data;
   assign o_result       = r_result;
   assign o_result_valid = r_valid;
   assign o_timeout      = r_timeout;
endmodule

// File: tb/tb_alu_uart_host.sv
// tb_alu_uart_host: directed checks of command serialization, result/timeout return and reset abort.
module tb_alu_uart_host;
   localparam int TO = 100;
   logic       i_clk = 1'b0;
   logic       i_reset = 1'b0;
   logic       i_cmd_valid = 1'b0;
   logic       o_cmd_ready;
   logic [7:0] i_data_a = 8'h00;
   logic [7:0] i_data_b = 8'h00;
   logic [5:0] i_op = 6'h00;
   logic       o_tx_start;
   logic [7:0] o_tx_data;
   logic       i_tx_done = 1'b0;
   logic       i_rx_done = 1'b0;
   logic [7:0] i_rx_data = 8'h00;
   logic [7:0] o_result;
   logic       o_result_valid;
   logic       o_timeout;
   logic       o_busy;
   int total = 0, bad = 0;
   int nvalid = 0, ntmo = 0, nstart = 0;
   int v0, t0, s0;

   always #5 i_clk = ~i_clk;

   alu_uart_host #(.TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_data_a(i_data_a), .i_data_b(i_data_b), .i_op(i_op),
      .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done(i_tx_done),
      .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
      .o_result(o_result), .o_result_valid(o_result_valid),
      .o_timeout(o_timeout), .o_busy(o_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge i_clk);
      nvalid += int'(o_result_valid);
      ntmo   += int'(o_timeout);
      nstart += int'(o_tx_start);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, o_cmd_ready, 1);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_start"}, o_tx_start, 0);
      chk({tag, "_txdata"}, o_tx_data, 0);
      chk({tag, "_result"}, o_result, 0);
      chk({tag, "_valid"}, o_result_valid, 0);
      chk({tag, "_timeout"}, o_timeout, 0);
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      chk("issue_ready", o_cmd_ready, 1);
      i_cmd_valid = 1'b1;
      i_data_a = a;
      i_data_b = b;
      i_op = op;
      tick;
      i_cmd_valid = 1'b0;
      i_data_a = 8'($urandom);
      i_data_b = 8'($urandom);
      i_op = 6'($urandom);
      chk("accept_latency", o_tx_start, 1);
      chk("accept_busy", o_busy, 1);
      chk("accept_ready", o_cmd_ready, 0);
   endtask

   task automatic xbyte(input logic [7:0] e, input bit stray);
      chk("tx_start", o_tx_start, 1);
      chk("tx_data", o_tx_data, e);
      for (int i = 1; i <= 10; i++) begin
         if (stray && i == 5) begin
            i_rx_done = 1'b1;
            i_rx_data = 8'hAA;
         end
         tick;
         i_rx_done = 1'b0;
         if (i == 1) chk("tx_start_pulse", o_tx_start, 0);
         if (stray && i == 6) begin
            chk("stray_valid", o_result_valid, 0);
            chk("stray_result", o_result, 8'h08);
         end
      end
      chk("tx_hold", o_tx_data, e);
      i_tx_done = 1'b1;
      tick;
      i_tx_done = 1'b0;
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op, input bit stray);
      issue(a, b, op);
      xbyte(a, 1'b0);
      xbyte(b, stray);
      xbyte({2'b00, op}, 1'b0);
      chk("wait_rx_start", o_tx_start, 0);
      chk("wait_rx_busy", o_busy, 1);
   endtask

   task automatic answer(input logic [7:0] d);
      i_rx_done = 1'b1;
      i_rx_data = d;
      tick;
      i_rx_done = 1'b0;
      i_rx_data = 8'h00;
      chk("rx_result", o_result, d);
      chk("rx_valid", o_result_valid, 1);
      chk("rx_ready", o_cmd_ready, 1);
      chk("rx_timeout", o_timeout, 0);
      tick;
      chk("rx_valid_pulse", o_result_valid, 0);
   endtask

   initial begin
      repeat (3) tick;
      chk_reset_outputs("reset");
      i_reset = 1'b1;
      tick;

      v0 = nvalid; t0 = ntmo;
      send3(8'h05, 8'h03, 6'h20, 1'b0);
      repeat (5) tick;
      answer(8'h08);
      chk("add_valid_count", nvalid - v0, 1);
      chk("add_timeout_count", ntmo - t0, 0);

      t0 = ntmo; s0 = nstart;
      send3(8'h01, 8'h02, 6'h03, 1'b0);
      s0 = nstart;
      for (int i = 1; i <= TO - 1; i++) begin
         if (i == 10) i_tx_done = 1'b1;
         tick;
         i_tx_done = 1'b0;
      end
      chk("to_early", ntmo - t0, 0);
      chk("to_stray_txdone", nstart - s0, 0);
      tick;
      chk("to_pulse", o_timeout, 1);
      chk("to_result_kept", o_result, 8'h08);
      chk("to_no_valid", o_result_valid, 0);
      chk("to_ready", o_cmd_ready, 1);
      tick;
      chk("to_pulse_end", o_timeout, 0);
      chk("to_ready_next", o_cmd_ready, 1);

      v0 = nvalid;
      send3(8'h33, 8'h44, 6'h05, 1'b1);
      answer(8'h11);
      chk("stray_valid_count", nvalid - v0, 1);

      chk("b2b_ready", o_cmd_ready, 1);
      i_cmd_valid = 1'b1;
      i_data_a = 8'h0F; i_data_b = 8'h01; i_op = 6'h24;
      tick;
      i_data_a = 8'hF0; i_data_b = 8'h0F; i_op = 6'h25;
      xbyte(8'h0F, 1'b0);
      chk("b2b_held_off", o_cmd_ready, 0);
      xbyte(8'h01, 1'b0);
      xbyte(8'h24, 1'b0);
      repeat (3) tick;
      chk("b2b_not_accepted", o_busy, 1);
      i_rx_done = 1'b1;
      i_rx_data = 8'h01;
      tick;
      i_rx_done = 1'b0;
      chk("b2b_result1", o_result, 8'h01);
      chk("b2b_valid1", o_result_valid, 1);
      chk("b2b_ready1", o_cmd_ready, 1);
      chk("b2b_no_start", o_tx_start, 0);
      tick;
      i_cmd_valid = 1'b0;
      xbyte(8'hF0, 1'b0);
      xbyte(8'h0F, 1'b0);
      xbyte(8'h25, 1'b0);
      answer(8'hFF);

      issue(8'h5A, 8'hA5, 6'h01);
      xbyte(8'h5A, 1'b0);
      repeat (3) tick;
      i_reset = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      s0 = nstart; v0 = nvalid; t0 = ntmo;
      repeat (2) tick;
      i_reset = 1'b1;
      repeat (20) tick;
      chk("midrst_no_start", nstart - s0, 0);
      chk("midrst_no_valid", nvalid - v0, 0);
      chk("midrst_no_timeout", ntmo - t0, 0);
      chk("midrst_idle", o_busy, 0);
      send3(8'h07, 8'h08, 6'h21, 1'b0);
      answer(8'h0F);

      t0 = ntmo;
      send3(8'h09, 8'h0A, 6'h22, 1'b0);
      repeat (TO - 1) tick;
      answer(8'h42);
      chk("race_timeout_count", ntmo - t0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
